// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (multiplier and divider):
// FSM state encoding and the width helper used to size iteration counters.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } arith_state_e;

  // floor(log2(v)); ld(v)+1 bits always hold the value v itself
  function automatic int ld(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    while (x > 1) begin
      x = x >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier, W x W -> 2W, one product bit per cycle,
// unsigned or two's-complement signed, trigger/ready/done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready=1, waiting for str_trg; operands loaded on accept
// ST_OP   | one shift-and-add iteration per cycle, W cycles
// ST_FIX  | apply sign to the 2W-bit magnitude, publish result
// ST_DONE | done_trg=1 for one cycle, then back to idle
module mul_seq
  import arith_pkg::*;
#(
  parameter int W    = 32,
  parameter int CBIT = ld(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         str_trg,
  input  logic         sgn,
  input  logic [W-1:0] mcnd,
  input  logic [W-1:0] mplr,
  output logic         ready,
  output logic         done_trg,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo
);

  arith_state_e state_q, state_d;

  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    res_hi_q, res_hi_d;
  logic [W-1:0]    res_lo_q, res_lo_d;
  logic            neg_q, neg_d;
  logic [CBIT-1:0] n_q, n_d;

  logic [W:0]      sum;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_fix;
  logic [W-1:0]    mcnd_mag;
  logic [W-1:0]    mplr_mag;

  // The most negative operand negates to itself, which read as unsigned is the
  // correct magnitude 2^(W-1).
  always_comb begin
    mcnd_mag = (sgn && mcnd[W-1]) ? -mcnd : mcnd;
    mplr_mag = (sgn && mplr[W-1]) ? -mplr : mplr;
  end

  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  end

  always_comb begin
    acc     = {hi_q, lo_q};
    acc_fix = neg_q ? -acc : acc;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    n_d      = n_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (str_trg) begin
          neg_d   = sgn & (mcnd[W-1] ^ mplr[W-1]);
          a_d     = mcnd_mag;
          lo_d    = mplr_mag;
          hi_d    = '0;
          n_d     = CBIT'(W);
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        // {c,s,lo} >> 1: carry enters hi, sum LSB shifts into lo
        hi_d = sum[W:1];
        lo_d = {sum[0], lo_q[W-1:1]};
        n_d  = n_q - CBIT'(1);
        if (n_q == CBIT'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        {hi_d, lo_d}         = acc_fix;
        {res_hi_d, res_lo_d} = acc_fix;
        state_d              = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      n_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      n_q      <= n_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done_trg = (state_q == ST_DONE);
  assign prod_hi  = res_hi_q;
  assign prod_lo  = res_lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector and random checks for mul_seq at W=32: results, latency,
// busy-ignore, result hold, mid-operation reset and back-to-back throughput.
module tb_mul_seq;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          str_trg;
  logic          sgn;
  logic [W-1:0]  mcnd;
  logic [W-1:0]  mplr;
  logic          ready;
  logic          done_trg;
  logic [W-1:0]  prod_hi;
  logic [W-1:0]  prod_lo;

  int checks;
  int failures;

  mul_seq #(.W(W), .CBIT(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .str_trg  (str_trg),
    .sgn      (sgn),
    .mcnd     (mcnd),
    .mplr     (mplr),
    .ready    (ready),
    .done_trg (done_trg),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    if (s) begin
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return sp;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Wait for idle, present operands for exactly one accepting edge (T0).
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    sgn     = s;
    mcnd    = a;
    mplr    = b;
    str_trg = 1'b1;
    @(posedge clk);
    #1;
    str_trg = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat);
    launch(s, a, b);
    lat = 0;
    for (int k = 1; k <= W + 20; k++) begin
      @(posedge clk);
      #1;
      if (done_trg) begin
        lat = k;
        break;
      end
    end
    prod = {prod_hi, prod_lo};
  endtask

  vec_t        vecs[12];
  logic [63:0] p;
  int          lat;

  initial begin
    checks   = 0;
    failures = 0;
    str_trg  = 1'b0;
    sgn      = 1'b0;
    mcnd     = '0;
    mplr     = '0;
    reset    = 1'b1;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[3]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[4]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vecs[6]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000};
    vecs[7]  = '{1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000};
    vecs[8]  = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE};
    vecs[11] = '{1'b1, 32'h00000002, 32'h00000003, 64'h00000000_00000006};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, ready}, 64'd1);
    chk("reset_done", {63'b0, done_trg}, 64'd0);
    chk("reset_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
      chk($sformatf("vec%0d_prod", i), p, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
    end

    // busy ignore + result hold
    begin
      int ndone, first_lat, ready_bad, hold_bad;
      logic [63:0] first_p;
      ndone = 0; first_lat = 0; ready_bad = 0; hold_bad = 0; first_p = '0;
      launch(1'b0, 32'd7, 32'd6);
      for (int k = 1; k <= W + 15; k++) begin
        if (k == 5) begin
          sgn = 1'b0; mcnd = 32'd9; mplr = 32'd9; str_trg = 1'b1;
        end
        @(posedge clk);
        #1;
        str_trg = 1'b0;
        if (done_trg) begin
          ndone++;
          if (ndone == 1) begin
            first_lat = k;
            first_p   = {prod_hi, prod_lo};
          end
        end else if (ndone > 0 && {prod_hi, prod_lo} != 64'd42) begin
          hold_bad++;
        end
        if (ndone == 0 && ready) ready_bad++;
        if (done_trg && ready) ready_bad++;
      end
      chk("busy_done_count", 64'(ndone), 64'd1);
      chk("busy_latency", 64'(first_lat), 64'(W + 1));
      chk("busy_prod", first_p, 64'd42);
      chk("busy_ready_low", 64'(ready_bad), 64'd0);
      chk("hold_prod", 64'(hold_bad), 64'd0);
    end

    // reset in the middle of an operation
    begin
      int dcount;
      dcount = 0;
      launch(1'b0, 32'h1234, 32'h5678);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_ready", {63'b0, ready}, 64'd1);
      chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        if (done_trg) dcount++;
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < W + 5; k++) begin
        @(posedge clk);
        #1;
        if (done_trg) dcount++;
      end
      chk("midrst_no_done", 64'(dcount), 64'd0);
      run_op(1'b0, 32'd3, 32'd4, p, lat);
      chk("after_rst_prod", p, 64'd12);
      chk("after_rst_latency", 64'(lat), 64'(W + 1));
    end

    // back-to-back with str_trg held high, random operands
    begin
      localparam int N = 1000;
      logic [63:0] expq[$];
      logic [31:0] ra, rb;
      logic        rs;
      int launched, received, cyc, last_done, gap_bad, prod_bad;
      launched = 0; received = 0; cyc = 0; last_done = -1; gap_bad = 0; prod_bad = 0;
      while (received < N && cyc < N * (W + 3) + 200) begin
        @(negedge clk);
        if (ready && launched < N) begin
          rs = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 7))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            2: ra = 32'h0;
            default: ra = $urandom;
          endcase
          case ($urandom_range(0, 7))
            0: rb = 32'h80000000;
            1: rb = 32'h1;
            2: rb = 32'h7FFFFFFF;
            default: rb = $urandom;
          endcase
          sgn = rs; mcnd = ra; mplr = rb; str_trg = 1'b1;
          expq.push_back(model(rs, ra, rb));
          launched++;
        end else if (ready) begin
          str_trg = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done_trg) begin
          if (expq.size() == 0) begin
            prod_bad++;
            $display("FAIL b2b_spurious_done: got done at cycle %0d want none", cyc);
          end else begin
            logic [63:0] e;
            e = expq.pop_front();
            if ({prod_hi, prod_lo} !== e) begin
              prod_bad++;
              if (prod_bad <= 5)
                $display("FAIL b2b_prod: got %h want %h", {prod_hi, prod_lo}, e);
            end
          end
          if (last_done >= 0 && cyc - last_done != W + 3) gap_bad++;
          last_done = cyc;
          received++;
        end
      end
      str_trg = 1'b0;
      chk("b2b_received", 64'(received), 64'(N));
      chk("b2b_prod_errors", 64'(prod_bad), 64'd0);
      chk("b2b_gap_errors", 64'(gap_bad), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
